// File: rtl/hazard_ctrl_unit.sv
// rtl/hazard_ctrl_unit.sv - MIPS ID-stage hazard controller with in-flight load scoreboard
// Stall length is set by how far each load has advanced through the memory pipeline.
module hazard_ctrl_unit #(
  parameter int REG_W      = 5,
  parameter int MEM_LAT    = 1,
  parameter int DELAY_SLOT = 0,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_branch,
  input  logic             br_taken,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             dmem_stall,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_freeze,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] freeze_cycles,
  output logic [CNT_W-1:0] flush_count
);

  function automatic logic dep(input logic [REG_W-1:0] r,
                               input logic [REG_W-1:0] rs,
                               input logic [REG_W-1:0] rt,
                               input logic             urs,
                               input logic             urt);
    return (r != '0) && ((urs && (r == rs)) || (urt && (r == rt)));
  endfunction

  // Entry k describes the load currently occupying memory stage Mk.
  logic [MEM_LAT:1] sb_v;
  logic [REG_W-1:0] sb_rd [1:MEM_LAT];

  logic ex_load;
  logic ex_dep;
  logic sb_lu_hit;
  logic sb_br_hit;
  logic hazard;
  logic flush_req;

  assign ex_load = ex_mem_read && ex_reg_write;
  assign ex_dep  = dep(ex_rd, id_rs, id_rt, id_uses_rs, id_uses_rt);

  // A plain consumer can take the value from WB once the load sits in the last
  // memory stage; a branch compares in ID and must wait until the load retires.
  always_comb begin
    sb_lu_hit = 1'b0;
    sb_br_hit = 1'b0;
    for (int k = 1; k <= MEM_LAT; k++) begin
      if (sb_v[k] && dep(sb_rd[k], id_rs, id_rt, id_uses_rs, id_uses_rt)) begin
        sb_br_hit = 1'b1;
        if (k < MEM_LAT) sb_lu_hit = 1'b1;
      end
    end
  end

  assign hazard = (ex_load && ex_dep) || sb_lu_hit ||
                  (id_branch && ((ex_reg_write && ex_dep) || sb_br_hit));

  assign flush_req = id_branch && br_taken && (DELAY_SLOT == 0);

  always_comb begin
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_freeze = 1'b0;
    if (rst) begin
      pc_hold = 1'b0;
    end else if (dmem_stall) begin
      pipe_freeze = 1'b1;
      pc_hold     = 1'b1;
      ifid_hold   = 1'b1;
    end else if (hazard) begin
      pc_hold     = 1'b1;
      ifid_hold   = 1'b1;
      idex_bubble = 1'b1;
    end else if (flush_req) begin
      ifid_flush = 1'b1;
    end
  end

  // Bubbles leave EX describing the real instruction, so capture is unconditional
  // except during a freeze, when the memory pipeline does not advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_v <= '0;
      for (int k = 1; k <= MEM_LAT; k++) sb_rd[k] <= '0;
    end else if (!dmem_stall) begin
      sb_v[1]  <= ex_load && (ex_rd != '0);
      sb_rd[1] <= ex_rd;
      for (int k = MEM_LAT; k >= 2; k--) begin
        sb_v[k]  <= sb_v[k-1];
        sb_rd[k] <= sb_rd[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles  <= '0;
      freeze_cycles <= '0;
      flush_count   <= '0;
    end else begin
      if (pipe_freeze) freeze_cycles <= freeze_cycles + CNT_W'(1);
      if (idex_bubble) stall_cycles  <= stall_cycles + CNT_W'(1);
      if (ifid_flush)  flush_count   <= flush_count + CNT_W'(1);
    end
  end

endmodule
